// File: rtl/wishbus_pkg.sv
// Purpose: shared types and constants for wishbus bus masters.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package wishbus_pkg;

  // Burst-reader FSM states, in the order a word moves through them.
  typedef enum logic [2:0] {
    rd_idle,
    rd_req,
    rd_issue,
    rd_wait_busy,
    rd_wait_done,
    rd_next,
    rd_release
  } rd_state_t;

  // Byte-address increment between consecutive 16-bit words.
  localparam int WB_ADDR_STEP = 2;

  // States in which the reader owns the bus unconditionally. REQ is handled
  // separately because it only requests the bus once the FIFO has room.
  function automatic logic rd_holds_bus(rd_state_t s);
    return (s == rd_issue) || (s == rd_wait_busy) ||
           (s == rd_wait_done) || (s == rd_next);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Purpose: generic synchronous first-word-fall-through FIFO.
// Latency: written word visible on rd_dat the cycle after the push.
// Backpressure: full/empty/count registered; push on full is accepted only with a same-cycle pop.
//
// Ports:
//   clk_i, rst_i       clock, asynchronous active-low reset
//   wr_vld, wr_dat     push request and data
//   rd_rdy, rd_dat     pop request and head data (valid while !empty)
//   full, empty, count occupancy flags and entry count
// FIFO_DEPTH must be a power of two and at least 2 so the pointers wrap
// naturally.
module sync_fifo #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          wr_vld,
  input  logic [DATA_W-1:0]             wr_dat,
  input  logic                          rd_rdy,
  output logic [DATA_W-1:0]             rd_dat,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_wr;
  logic              do_rd;
  logic [CNT_W-1:0]  count_nxt;

  always_comb begin
    do_rd     = rd_rdy && !empty;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    do_wr     = wr_vld && (!full || do_rd);
    count_nxt = count + CNT_W'(do_wr) - CNT_W'(do_rd);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_rd) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_nxt;
      full  <= (count_nxt == DEPTH_C);
      empty <= (count_nxt == '0);
    end
  end

  // Storage needs no reset: entries are only read once written.
  always_ff @(posedge clk_i) begin
    if (do_wr) mem[wr_ptr] <= wr_dat;
  end

  assign rd_dat = mem[rd_ptr];

endmodule

// File: rtl/wishbus_burst_reader.sv
// Purpose: wishbus master that reads len_i 16-bit words from base_addr_i into a FIFO.
// Latency: 5 cycles per word while holding the grant; q_valid_o rises 4 cycles after the strobe.
// Backpressure: drops its bus request when the FIFO is full and re-arbitrates once a slot frees.
//
// Ports:
//   start_i/base_addr_i/len_i  burst launch, sampled while idle
//   busy_o, done_o             burst in progress / last word written
//   q_data_o/q_valid_o/q_ready_i  output stream (FIFO head, fall-through)
//   mem_*                      master side of the wishbus (device-side names)
module wishbus_burst_reader
  import wishbus_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 16,
  parameter int LEN_W      = 10,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [LEN_W-1:0]  len_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] q_data_o,
  output logic              q_valid_o,
  input  logic              q_ready_i,
  output logic              mem_rst_i,
  output logic              mem_we_i,
  output logic [DATA_W-1:0] mem_dat_o,
  output logic              mem_stb_i,
  output logic [ADDR_W-1:0] mem_addr_i,
  output logic              mem_sel_i,
  input  logic              mem_ack_o,
  input  logic              mem_cyc_o,
  input  logic              mem_stb_o,
  input  logic [DATA_W-1:0] mem_dat_i
);

  rd_state_t         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  remaining_q, remaining_d;
  logic [ADDR_W-1:0] bus_addr_d;
  logic              sel_d, stb_d, busy_d, done_d;
  logic              push;

  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_pop;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  assign fifo_pop = !fifo_empty && q_ready_i;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    done_d      = 1'b0;
    push        = 1'b0;

    case (state_q)
      rd_idle: begin
        if (start_i) begin
          addr_d      = base_addr_i;
          remaining_d = len_i;
          if (len_i == '0) done_d  = 1'b1;
          else             state_d = rd_req;
        end
      end
      // mem_sel_i is only low here once the FIFO has room, so an ack seen
      // with the request low is a real grant for a slot we can fill.
      rd_req:       if (!mem_sel_i && mem_ack_o) state_d = rd_issue;
      rd_issue:     state_d = rd_wait_busy;
      rd_wait_busy: if (mem_cyc_o) state_d = rd_wait_done;
      rd_wait_done: begin
        if (!mem_cyc_o) begin
          push        = 1'b1;
          addr_d      = addr_q + ADDR_W'(WB_ADDR_STEP);
          remaining_d = remaining_q - 1'b1;
          state_d     = rd_next;
          // done_o is registered, so raising it here makes it visible in
          // NEXT, the cycle after the last push.
          if (remaining_q == LEN_W'(1)) done_d = 1'b1;
        end
      end
      rd_next: begin
        if (remaining_q == '0 || fifo_full) state_d = rd_release;
        else                                state_d = rd_issue;
      end
      rd_release:   state_d = (remaining_q == '0) ? rd_idle : rd_req;
      default:      state_d = rd_idle;
    endcase

    // Bus outputs are registered from the next state so they line up with
    // the state they belong to. Neither IDLE nor RELEASE nor REQ ever
    // pushes, so in those states the FIFO is full next cycle only if it is
    // full now and nothing pops.
    busy_d     = (state_d != rd_idle);
    stb_d      = (state_d == rd_issue);
    bus_addr_d = stb_d ? addr_q : mem_addr_i;
    sel_d      = !(rd_holds_bus(state_d) ||
                   (state_d == rd_req && !(fifo_full && !fifo_pop)));
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= rd_idle;
      addr_q      <= '0;
      remaining_q <= '0;
      mem_sel_i   <= 1'b1;
      mem_stb_i   <= 1'b0;
      mem_addr_i  <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      mem_sel_i   <= sel_d;
      mem_stb_i   <= stb_d;
      mem_addr_i  <= bus_addr_d;
      busy_o      <= busy_d;
      done_o      <= done_d;
    end
  end

  sync_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .wr_vld (push),
    .wr_dat (mem_dat_i),
    .rd_rdy (q_ready_i),
    .rd_dat (q_data_o),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  assign q_valid_o = !fifo_empty;

  // Read-only master: the bus reset, write enable and write data are fixed.
  assign mem_rst_i = 1'b0;
  assign mem_we_i  = 1'b1;
  assign mem_dat_o = '0;

  // The device's strobe echo and the FIFO count are not needed here.
  logic unused_sinks;
  assign unused_sinks = &{1'b0, mem_stb_o, fifo_count};

endmodule

// File: tb/tb_wishbus_burst_reader.sv
module tb_wishbus_burst_reader;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic [31:0] base_addr_i = '0;
  logic [9:0]  len_i = '0;
  logic        busy_o, done_o, q_valid_o;
  logic [15:0] q_data_o;
  logic        q_ready_i = 1'b0;
  logic        mem_rst_i, mem_we_i, mem_stb_i, mem_sel_i;
  logic [15:0] mem_dat_o;
  logic [31:0] mem_addr_i;
  logic        mem_ack_o = 1'b0;
  logic        mem_cyc_o = 1'b0;
  logic [15:0] mem_dat_i = '0;

  wishbus_burst_reader dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .base_addr_i(base_addr_i),
    .len_i(len_i), .busy_o(busy_o), .done_o(done_o), .q_data_o(q_data_o),
    .q_valid_o(q_valid_o), .q_ready_i(q_ready_i), .mem_rst_i(mem_rst_i),
    .mem_we_i(mem_we_i), .mem_dat_o(mem_dat_o), .mem_stb_i(mem_stb_i),
    .mem_addr_i(mem_addr_i), .mem_sel_i(mem_sel_i), .mem_ack_o(mem_ack_o),
    .mem_cyc_o(mem_cyc_o), .mem_stb_o(mem_cyc_o), .mem_dat_i(mem_dat_i)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // ---------------- environment: RAM device + arbiter ----------------
  logic [15:0] ram [0:63];
  int          ph = 0;
  logic [31:0] cap_addr = '0;
  logic        granted = 1'b0;
  int          dup_err = 0;
  int          cyc = 0;
  int          block_until = 0;
  bit          spurious = 1'b0;
  int          ready_mode = 0;

  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ph <= 0; mem_cyc_o <= 1'b0; mem_ack_o <= 1'b0; granted <= 1'b0;
    end else begin
      // RAM adapter: cyc_o high for two cycles after the strobe, then low
      // with the read data.
      if (ph == 0) begin
        if (mem_stb_i) begin mem_cyc_o <= 1'b1; ph <= 2; cap_addr <= mem_addr_i; end
      end else if (ph == 2) begin
        ph <= 1;
        if (mem_stb_i) dup_err <= dup_err + 1;
      end else begin
        ph <= 0; mem_cyc_o <= 1'b0; mem_dat_i <= ram[cap_addr[6:1]];
        if (mem_stb_i) dup_err <= dup_err + 1;
      end
      // Arbiter: one grant pulse per request unless another master holds
      // the bus; optional stray acks while the grant is held.
      mem_ack_o <= 1'b0;
      if (mem_sel_i) granted <= 1'b0;
      else if (!granted && cyc >= block_until) begin mem_ack_o <= 1'b1; granted <= 1'b1; end
      else if (granted && spurious && $urandom_range(0, 3) == 0) mem_ack_o <= 1'b1;
    end
  end

  always @(posedge clk_i) begin
    #1;
    case (ready_mode)
      0: q_ready_i = 1'b0;
      1: q_ready_i = 1'b1;
      default: q_ready_i = 1'($urandom_range(0, 1));
    endcase
  end

  // ---------------- monitor ----------------
  logic [15:0] pop_q[$];
  logic [31:0] stb_q[$];
  int done_cnt = 0, stb_sel_err = 0, sel_low_cnt = 0;
  int blk_sel_low = 0, blk_stb = 0;
  int last_stb_cyc = 0, rise_cyc = 0, done_cyc = 0;
  logic prev_valid = 1'b0;

  always @(negedge clk_i) begin
    cyc = cyc + 1;
    if (rst_i) begin
      if (q_valid_o && q_ready_i) pop_q.push_back(q_data_o);
      if (mem_stb_i) begin
        stb_q.push_back(mem_addr_i);
        last_stb_cyc = cyc;
        if (mem_sel_i) stb_sel_err++;
        if (cyc < block_until) blk_stb++;
      end
      if (!mem_sel_i) begin
        sel_low_cnt++;
        if (cyc < block_until) blk_sel_low++;
      end
      if (done_o) begin done_cnt++; done_cyc = cyc; end
      if (q_valid_o && !prev_valid) rise_cyc = cyc;
    end
    prev_valid = q_valid_o;
  end

  // ---------------- burst helpers ----------------
  logic [31:0] cur_base;
  int cur_len, p0, s0, d0;

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic start_burst(input logic [31:0] b, input int l);
    cur_base = b; cur_len = l;
    p0 = pop_q.size(); s0 = stb_q.size(); d0 = done_cnt;
    @(posedge clk_i); #1;
    start_i = 1'b1; base_addr_i = b; len_i = l[9:0];
    @(posedge clk_i); #1;
    start_i = 1'b0;
  endtask

  // Expected: words at base+2k (32-bit wrap) for k < len, in order, with one
  // strobe per word at that address and one done pulse.
  task automatic finish_burst(input string tag);
    int n;
    logic [31:0] a;
    n = 0;
    while ((pop_q.size() - p0 < cur_len || busy_o) && n < 4000) begin tick(1); n++; end
    tick(3);
    checks++;
    if (n >= 4000) begin errors++; $display("FAIL %s timeout: popped %0d want %0d", tag, pop_q.size() - p0, cur_len); end
    checks++;
    if (done_cnt != d0 + 1) begin errors++; $display("FAIL %s done pulses: got %0d want 1", tag, done_cnt - d0); end
    checks++;
    if (stb_q.size() - s0 != cur_len) begin errors++; $display("FAIL %s strobes: got %0d want %0d", tag, stb_q.size() - s0, cur_len); end
    checks++;
    if (pop_q.size() - p0 != cur_len) begin errors++; $display("FAIL %s words: got %0d want %0d", tag, pop_q.size() - p0, cur_len); end
    checks++;
    if (mem_sel_i !== 1'b1 || busy_o !== 1'b0) begin errors++; $display("FAIL %s idle: sel=%b busy=%b want sel=1 busy=0", tag, mem_sel_i, busy_o); end
    for (int k = 0; k < cur_len; k++) begin
      a = cur_base + 32'(2 * k);
      if (s0 + k < stb_q.size()) begin
        checks++;
        if (stb_q[s0 + k] !== a) begin errors++; $display("FAIL %s addr[%0d]: got %h want %h", tag, k, stb_q[s0 + k], a); end
      end
      if (p0 + k < pop_q.size()) begin
        checks++;
        if (pop_q[p0 + k] !== ram[a[6:1]]) begin errors++; $display("FAIL %s data[%0d]: got %h want %h", tag, k, pop_q[p0 + k], ram[a[6:1]]); end
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (mem_sel_i !== 1'b1 || mem_stb_i !== 1'b0 || mem_addr_i !== 32'h0 ||
        busy_o !== 1'b0 || done_o !== 1'b0 || q_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL %s: sel=%b stb=%b addr=%h busy=%b done=%b valid=%b want 1 0 0 0 0 0",
               tag, mem_sel_i, mem_stb_i, mem_addr_i, busy_o, done_o, q_valid_o);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #2 rst_i = 1'b0;
    tick(3);
    check_reset_outputs("reset");
    checks++;
    if (mem_rst_i !== 1'b0 || mem_we_i !== 1'b1 || mem_dat_o !== 16'h0) begin
      errors++; $display("FAIL reset constants: rst=%b we=%b dat=%h want 0 1 0000", mem_rst_i, mem_we_i, mem_dat_o);
    end
    rst_i = 1'b1;
    tick(2);
  endtask

  task automatic test_single();
    ram[8] = 16'hBEEF;
    ready_mode = 1;
    start_burst(32'h10, 1);
    finish_burst("single");
    checks++;
    if (rise_cyc - last_stb_cyc != 4) begin errors++; $display("FAIL single valid latency: got %0d want 4", rise_cyc - last_stb_cyc); end
    checks++;
    if (done_cyc - last_stb_cyc != 4) begin errors++; $display("FAIL single done timing: got %0d want 4", done_cyc - last_stb_cyc); end
  endtask

  task automatic test_backpressure();
    ready_mode = 0;
    tick(2);
    start_burst(32'h0, 20);
    // Long enough for 8 words at 5 cycles each plus arbitration.
    tick(60);
    checks++;
    if (stb_q.size() - s0 != 8) begin errors++; $display("FAIL bp stalled strobes: got %0d want 8", stb_q.size() - s0); end
    checks++;
    if (mem_sel_i !== 1'b1 || busy_o !== 1'b1 || q_valid_o !== 1'b1) begin
      errors++; $display("FAIL bp stall state: sel=%b busy=%b valid=%b want 1 1 1", mem_sel_i, busy_o, q_valid_o);
    end
    ready_mode = 2;
    finish_burst("burst20");
  endtask

  task automatic test_zero_len();
    int sl;
    ready_mode = 1;
    sl = sel_low_cnt;
    start_burst(32'h1234, 0);
    checks++;
    if (done_o !== 1'b1 || busy_o !== 1'b0) begin errors++; $display("FAIL zero done: done=%b busy=%b want 1 0", done_o, busy_o); end
    tick(1);
    checks++;
    if (done_o !== 1'b0) begin errors++; $display("FAIL zero done width: done=%b want 0", done_o); end
    tick(5);
    checks++;
    if (sel_low_cnt != sl || stb_q.size() != s0 || busy_o !== 1'b0 || done_cnt != d0 + 1) begin
      errors++; $display("FAIL zero bus: sel_low=%0d strobes=%0d busy=%b dones=%0d want 0 0 0 1",
                         sel_low_cnt - sl, stb_q.size() - s0, busy_o, done_cnt - d0);
    end
  endtask

  task automatic test_contention();
    int bl, bs;
    ready_mode = 2;
    spurious = 1'b1;
    bl = blk_sel_low; bs = blk_stb;
    block_until = cyc + 32;
    start_burst({$urandom} & 32'hFFFF_FFFE, 6);
    while (cyc < block_until) tick(1);
    checks++;
    if (blk_stb != bs) begin errors++; $display("FAIL contention strobe while blocked: got %0d want 0", blk_stb - bs); end
    checks++;
    if (blk_sel_low - bl < 25) begin errors++; $display("FAIL contention request held: got %0d cycles want >=25", blk_sel_low - bl); end
    finish_burst("contention");
    spurious = 1'b0;
  endtask

  task automatic test_wrap();
    ready_mode = 2;
    start_burst(32'hFFFF_FFFE, 2);
    finish_burst("wrap");
  endtask

  task automatic test_reset_mid();
    int n;
    ready_mode = 1;
    start_burst({$urandom} & 32'hFFFF_FFFE, 5);
    n = 0;
    while (!mem_cyc_o && n < 50) begin tick(1); n++; end
    checks++;
    if (n >= 50) begin errors++; $display("FAIL midreset no bus cycle: waited %0d want <50", n); end
    rst_i = 1'b0;
    #1;
    check_reset_outputs("midreset");
    tick(3);
    rst_i = 1'b1;
    tick(2);
    start_burst({$urandom} & 32'hFFFF_FFFE, 3);
    finish_burst("after_reset");
  endtask

  task automatic test_random_bursts();
    for (int i = 0; i < 6; i++) begin
      ready_mode = 2;
      spurious = 1'($urandom_range(0, 1));
      start_burst({$urandom} & 32'hFFFF_FFFE, $urandom_range(1, 12));
      finish_burst("random");
    end
    spurious = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) ram[i] = 16'($urandom);
    test_reset();
    test_single();
    test_backpressure();
    test_zero_len();
    test_contention();
    test_wrap();
    test_reset_mid();
    test_random_bursts();
    checks++;
    if (stb_sel_err != 0 || dup_err != 0) begin
      errors++; $display("FAIL bus protocol: stb_without_sel=%0d stb_during_cycle=%0d want 0 0", stb_sel_err, dup_err);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/wishbus_burst_reader.md
# wishbus_burst_reader

Bus master that fetches a block of `len_i` 16-bit words from a wishbus memory, starting at a byte address, into a small internal FIFO. It presents them downstream as a valid/ready stream. It sits upstream of the 4-port wishbus arbiter, on one of its user slots, and that slot is backed by the RAM-to-wishbus adapter. It is the fill engine for line buffers and display/DMA consumers.

## Interface
Parameters:
- `ADDR_W`, 32: byte-address width; matches `mem.addr_i`.
- `DATA_W`, 16: word width; matches `mem.dat_i`.
- `LEN_W`, 10: width of the word-count field.
- `FIFO_DEPTH`, 8: output FIFO entries; must be a power of two, ≥2.

Ports:
- `clk_i`, in, 1: the single clock.
- `rst_i`, in, 1: asynchronous, active-low reset.
- `start_i`, in, 1: one-cycle pulse that launches a burst; ignored while `busy_o` is high.
- `base_addr_i`, in, `ADDR_W`: start byte address, sampled on `start_i`.
- `len_i`, in, `LEN_W`: number of words, sampled on `start_i`.
- `busy_o`, out, 1: a burst is in progress.
- `done_o`, out, 1: one-cycle pulse when the last word has been written into the FIFO.
- `q_data_o`, out, `DATA_W`: FIFO head.
- `q_valid_o`, out, 1: the FIFO is non-empty.
- `q_ready_i`, in, 1: the consumer pops when `q_valid_o & q_ready_i`.
- `mem`, `mem_wif_t.dev`: the master side of the bus.
  - Driven: `rst_i` (constant 0), `we_i` (constant 1, read), `dat_o` (constant 0), `stb_i`, `addr_i`, `sel_i` (active-low request).
  - Sampled: `ack_o` (grant), `cyc_o`, `stb_o`, `dat_i`.

## Operation
- **Reset values** (while `rst_i`=0):
  - FSM = IDLE.
  - `mem.sel_i`=1, `mem.stb_i`=0, `mem.addr_i`=0.
  - `busy_o`=0, `done_o`=0.
  - FIFO empty (`q_valid_o`=0); `q_data_o` is don't-care.
  - Address and count registers = 0.
  - Reset mid-burst abandons the burst; any FIFO contents are lost.
- **IDLE**: on `start_i`, latch `addr`←`base_addr_i` and `remaining`←`len_i`.
  - If `len_i`=0: pulse `done_o` next cycle, touch nothing on the bus, stay IDLE.
  - Otherwise go to REQ with `busy_o`=1.
- **REQ**: stay here until the FIFO has a free slot. Then drive `sel_i`=0 and wait for `ack_o`=1, sampled, then go to ISSUE.
  - Repeat `ack_o` pulses while `sel_i` is held low are ignored.
- **ISSUE**: `stb_i`=1 for exactly one cycle, with `addr_i`=`addr`; then go to WAIT_BUSY.
- **WAIT_BUSY**: wait for `cyc_o`=1, then go to WAIT_DONE.
- **WAIT_DONE**: on the first cycle with `cyc_o`=0:
  - push `dat_i` into the FIFO;
  - `addr`←`addr`+2, modulo 2^`ADDR_W`, wrapping silently;
  - `remaining`←`remaining`−1;
  - go to NEXT.
- **NEXT**, evaluated in priority order:
  - If `remaining`=0: pulse `done_o`, go to RELEASE.
  - Else if the FIFO is full: go to RELEASE, then re-enter REQ, which waits for space.
  - Else: go to ISSUE, keeping the bus.
- **RELEASE**: `sel_i`=1 for at least one cycle, so other masters can win arbitration. Then go to IDLE if the burst is done, or to REQ if it is not.
- **Bus ownership**: `sel_i` is 0 from REQ through NEXT and 1 in all other states. `stb_i` is never high outside ISSUE.
- **FIFO**:
  - A push and a pop in the same cycle on a full FIFO are both legal; the count is unchanged.
  - A push never occurs when the FIFO is full, because free space is checked before each ISSUE and only one read is ever outstanding.
- `start_i` while busy has no effect.

## Timing
- Bus handshake, with ISSUE at cycle T:
  - the device raises `cyc_o` at T+1;
  - `cyc_o` falls with `dat_i` valid at T+3 (RAM adapter);
  - the FIFO push happens at the T+3 edge;
  - `q_valid_o` rises at T+4.
- Per-word throughput while holding the grant: 5 cycles (ISSUE, WAIT_BUSY, WAIT_DONE×2, NEXT).
- First-word latency from `start_i`: 1 cycle + arbitration wait + 5 cycles.
- `done_o` is asserted in the cycle after the last push. `busy_o` falls when RELEASE exits to IDLE.
- All outputs are registered. The FIFO read is first-word fall-through: `q_data_o` is valid in the same cycle as `q_valid_o`.

## Structure
- `wishbus_pkg`:
  - the FSM state enum (`rd_idle`, `rd_req`, `rd_issue`, `rd_wait_busy`, `rd_wait_done`, `rd_next`, `rd_release`);
  - the constant `WB_ADDR_STEP`=2.
- Sub-module `sync_fifo`, parameterised on `DATA_W` and `FIFO_DEPTH`.
  - Provides `full`, `empty` and `count`, with asynchronous active-low reset.
  - Reusable by other wishbus masters.
- The top level contains the FSM, the address/count registers and the bus drive.

## Test plan
- **Single-word read**: `base`=0x10, `len`=1, RAM model word 8 = 0xBEEF, immediate grant.
  - Exactly one `stb_i` pulse with `addr_i`=0x10.
  - `q_data_o`=0xBEEF, then `done_o` pulses.
  - `sel_i` returns to 1.
- **Full burst with back-pressure**: `len`=20, `FIFO_DEPTH`=8, `q_ready_i`=0 until 40 cycles after start.
  - After 8 words `sel_i` goes high and no further `stb_i` is issued.
  - Once popping begins, the burst resumes.
  - Data arrives in address order 0,2,4…38; `done_o` pulses once.
- **Zero length**: `start_i` with `len`=0.
  - `done_o` pulses the next cycle.
  - `sel_i` and `stb_i` never move; `busy_o` stays 0.
- **Arbitration contention**: another master holds the bus for 30 cycles.
  - Reader holds `sel_i`=0 in REQ with no `stb_i` until `ack_o`.
  - Extra `ack_o` pulses during the burst cause no duplicate ISSUE.
- **Address wrap**: `base`=0xFFFF_FFFE, `len`=2.
  - `addr_i` sequence 0xFFFF_FFFE then 0x0000_0000.
- **Reset mid-burst**: assert `rst_i`=0 during WAIT_BUSY.
  - All outputs take their reset values immediately.
  - A new start after release of reset works normally.
